prog_loader: RTL

// - Write-side driver of the processor's program-load port (addr / wr / wdata / working).
// - Receives a byte stream over a valid/ready handshake.
// - Packs the bytes into 32-bit instruction words and writes them to consecutive instruction addresses.
// - After the last word is written, asserts `working` so the processor runs.
// - Sits between a host byte source (UART RX or bench) and `processor`.
//

---
 rtl/prog_loader_pkg.sv | 28 ++
 rtl/prog_loader_if.sv | 34 +++
 rtl/prog_loader_word_assembler.sv | 54 +++++
 rtl/prog_loader.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, the default
// frame header byte, datapath widths and small state-decode helpers.
package prog_loader_pkg;

    localparam int unsigned WordW  = 32;  // instruction word width
    localparam int unsigned CountW = 8;   // word-count / word-index width

    localparam logic [7:0] SyncByteDefault = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StBytes,
        StWrite,
        StRun
    } state_e;

    // States in which a stream byte may be accepted.
    function automatic logic state_ready(state_e s);
        return (s == StIdle) || (s == StCount) || (s == StBytes);
    endfunction

    // States in which a load frame is in progress.
    function automatic logic state_busy(state_e s);
        return (s == StCount) || (s == StBytes) || (s == StWrite);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Signal bundle between a host byte source, the program loader and the
// processor program-load port.
//   master : loader view (consumes the byte stream, drives the load port)
//   slave  : host/processor view (drives the byte stream, observes the load port)
// Signals:
//   byte_in/byte_valid/byte_ready : byte stream handshake
//   restart                       : synchronous abort/restart request
//   addr/wr/wdata/working         : processor program-load port
//   busy/err                      : loader status
interface prog_loader_if;
    import prog_loader_pkg::*;

    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             byte_ready;
    logic             restart;
    logic [WordW-1:0] addr;
    logic             wr;
    logic [WordW-1:0] wdata;
    logic             working;
    logic             busy;
    logic             err;

    modport master (
        input  byte_in, byte_valid, restart,
        output byte_ready, addr, wr, wdata, working, busy, err
    );

    modport slave (
        output byte_in, byte_valid, restart,
        input  byte_ready, addr, wr, wdata, working, busy, err
    );

endinterface

// File: rtl/prog_loader_word_assembler.sv
// Packs accepted bytes big-endian into 32-bit words.
// Ports:
//   clock_i     : clock
//   reset_ni    : asynchronous active-low reset
//   clear_i     : synchronous clear of partial word and byte counter (wins over shift_i)
//   shift_i     : accept byte_i into the word
//   byte_i      : incoming byte
//   word_o      : assembled word including the byte currently presented
//   word_done_o : shift_i on the 4th byte of a word
module prog_loader_word_assembler
    import prog_loader_pkg::*;
(
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             clear_i,
    input  logic             shift_i,
    input  logic [7:0]       byte_i,
    output logic [WordW-1:0] word_o,
    output logic             word_done_o
);

    // Only the first three bytes need storage: the fourth is combined straight
    // from byte_i so the word can be registered on the same edge it completes.
    localparam int unsigned ShiftW = WordW - 8;

    logic [ShiftW-1:0] shift_q, shift_d;
    logic [1:0]        cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (shift_i) begin
            shift_d = {shift_q[ShiftW-9:0], byte_i};
            cnt_d   = cnt_q + 2'd1;  // wraps to 0 after the 4th byte
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word_o      = {shift_q, byte_i};
    assign word_done_o = shift_i && !clear_i && (cnt_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a framed byte stream (SyncByte, N, N*4 data bytes),
// writes the N big-endian words to consecutive addresses from BaseAddr, then
// holds working high so the processor runs.
// Ports:
//   clock_i  : clock, all state changes on posedge
//   reset_ni : asynchronous active-low reset; all outputs 0 while low
//   ld_if    : byte stream in, program-load port and status out (master view)
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0]       SyncByte = SyncByteDefault,
    parameter logic [WordW-1:0] BaseAddr = '0
) (
    input  logic          clock_i,
    input  logic          reset_ni,
    prog_loader_if.master ld_if
);

    state_e            state_q, state_d;
    logic [CountW-1:0] count_q, count_d;
    logic [CountW-1:0] index_q, index_d;
    logic [CountW:0]   index_inc;
    logic [WordW-1:0]  addr_q, addr_d;
    logic [WordW-1:0]  wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              working_q, working_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              asm_shift;
    logic              asm_clear;
    logic              word_done;
    logic [WordW-1:0]  word;

    // ready_q is a registered decode of the state so it is 0 during reset.
    assign accept    = ld_if.byte_valid && ready_q;
    assign asm_shift = accept && (state_q == StBytes);
    assign asm_clear = ld_if.restart || (accept && (state_q == StCount));
    assign index_inc = {1'b0, index_q} + {{CountW{1'b0}}, 1'b1};

    prog_loader_word_assembler u_word_assembler (
        .clock_i     (clock_i),
        .reset_ni    (reset_ni),
        .clear_i     (asm_clear),
        .shift_i     (asm_shift),
        .byte_i      (ld_if.byte_in),
        .word_o      (word),
        .word_done_o (word_done)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        index_d   = index_q;
        addr_d    = '0;
        wdata_d   = '0;
        wr_d      = 1'b0;
        working_d = 1'b0;
        err_d     = 1'b0;

        if (ld_if.restart) begin
            // Restart wins over any byte accepted on the same edge.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (ld_if.byte_in == SyncByte) begin
                            state_d = StCount;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                StCount: begin
                    if (accept) begin
                        if (ld_if.byte_in == 8'h00) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end else begin
                            count_d = ld_if.byte_in;
                            index_d = '0;
                            state_d = StBytes;
                        end
                    end
                end
                StBytes: begin
                    if (word_done) begin
                        wr_d    = 1'b1;
                        addr_d  = BaseAddr + {{(WordW - CountW){1'b0}}, index_q};
                        wdata_d = word;
                        state_d = StWrite;
                    end
                end
                StWrite: begin
                    index_d = index_inc[CountW-1:0];
                    if (index_inc == {1'b0, count_q}) begin
                        working_d = 1'b1;
                        state_d   = StRun;
                    end else begin
                        state_d = StBytes;
                    end
                end
                StRun: begin
                    working_d = 1'b1;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        ready_d = state_ready(state_d);
        busy_d  = state_busy(state_d);
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= StIdle;
            count_q   <= '0;
            index_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            working_q <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            index_q   <= index_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            working_q <= working_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign ld_if.byte_ready = ready_q;
    assign ld_if.addr       = addr_q;
    assign ld_if.wr         = wr_q;
    assign ld_if.wdata      = wdata_q;
    assign ld_if.working    = working_q;
    assign ld_if.busy       = busy_q;
    assign ld_if.err        = err_q;

endmodule
